exec_seq_ctrl: RTL



---
 rtl/exec_seq_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/exec_seq_ctrl.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer with commit strobes and instret.
// Define EXEC_SEQ_TIMEOUT_EN to add a per-stage wait counter that traps into ERR after TIMEOUT cycles.
module exec_seq_ctrl #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic             ifu_reqValid,
  input  logic             ifu_respValid,
  output logic             idu_reqValid,
  input  logic             idu_respValid,
  output logic             exu_reqValid,
  input  logic             exu_respValid,
  output logic             lsu_reqValid,
  input  logic             lsu_respValid,
  input  logic             dec_mem_op,
  input  logic             dec_rd_we,
  input  logic             dec_halt,
  output logic             pc_we,
  output logic             rf_we,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             busy,
  output logic             halted,
  output logic [2:0]       state_dbg,
  output logic             timeout_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

  if (TIMEOUT == 0) begin : g_timeout_check
    $error("exec_seq_ctrl: TIMEOUT must be at least 1");
  end

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic             first_q;
  logic             mem_q;
  logic             rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             owner_resp;
  logic             resp_ok;
  logic             in_stage;
  logic             tmo;

  // A response seen in the request cycle is never accepted (unit latency >= 1).
  always_comb begin
    owner_resp = 1'b0;
    case (state)
      S_FETCH:  owner_resp = ifu_respValid;
      S_DECODE: owner_resp = idu_respValid;
      S_EXEC:   owner_resp = exu_respValid;
      S_MEM:    owner_resp = lsu_respValid;
      default:  owner_resp = 1'b0;
    endcase
  end

  assign resp_ok  = owner_resp & ~first_q;
  assign in_stage = (state == S_FETCH) || (state == S_DECODE) ||
                    (state == S_EXEC)  || (state == S_MEM);

`ifdef EXEC_SEQ_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  logic [WAIT_W-1:0] wait_q;

  assign tmo = in_stage && !resp_ok && ((32'(wait_q) + 32'd1) >= TIMEOUT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_q <= '0;
    end else if (state_nxt != state) begin
      wait_q <= '0;
    end else if (in_stage) begin
      wait_q <= wait_q + 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH;
      S_FETCH: begin
        if (resp_ok)  state_nxt = S_DECODE;
        else if (tmo) state_nxt = S_ERR;
      end
      S_DECODE: begin
        if (resp_ok)  state_nxt = dec_halt ? S_HALT : S_EXEC;
        else if (tmo) state_nxt = S_ERR;
      end
      S_EXEC: begin
        if (resp_ok)  state_nxt = mem_q ? S_MEM : S_WB;
        else if (tmo) state_nxt = S_ERR;
      end
      S_MEM: begin
        if (resp_ok)  state_nxt = S_WB;
        else if (tmo) state_nxt = S_ERR;
      end
      S_WB:     state_nxt = start ? S_FETCH : S_IDLE;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_ERR;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      first_q <= 1'b0;
      mem_q   <= 1'b0;
      rd_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state   <= state_nxt;
      // Every stage is entered from a different state, so a state change marks its first cycle.
      first_q <= (state_nxt != state);
      if ((state == S_DECODE) && resp_ok) begin
        mem_q <= dec_mem_op;
        rd_q  <= dec_rd_we;
      end
      if (state == S_WB) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign ifu_reqValid = first_q && (state == S_FETCH);
  assign idu_reqValid = first_q && (state == S_DECODE);
  assign exu_reqValid = first_q && (state == S_EXEC);
  assign lsu_reqValid = first_q && (state == S_MEM);

  assign pc_we     = (state == S_WB);
  assign retire    = (state == S_WB);
  assign rf_we     = (state == S_WB) && rd_q;
  assign instret   = cnt_q;
  assign busy      = in_stage || (state == S_WB);
  assign halted    = (state == S_HALT);
  assign state_dbg = state;

`ifdef EXEC_SEQ_TIMEOUT_EN
  assign timeout_err = (state == S_ERR);
`else
  assign timeout_err = 1'b0;
`endif

endmodule
